// File: rtl/act_sram_pkg.sv
// rtl/act_sram_pkg.sv - shared constants and response tag type for the activation SRAM arbiter
package act_sram_pkg;
  localparam int ADDR_W      = 16;
  localparam int DATA_W      = 32;
  localparam int WEA_W       = 4;
  localparam int DEPTH       = 1024;
  localparam int NUM_REQ_MAX = 8;

  typedef struct packed {
    logic       vld;
    logic       port;
    logic [2:0] id;
  } rsp_tag_t;
endpackage

// File: rtl/act_rr_picker.sv
// rtl/act_rr_picker.sv - returns the first set mask bit at or after ptr_i, wrapping, plus a found flag
module act_rr_picker #(
  parameter int N = 3
) (
  input  logic [N-1:0] mask_i,
  input  logic [2:0]   ptr_i,
  output logic [2:0]   idx_o,
  output logic         found_o
);
  int j;

  // Walk the scan order backwards so the earliest hit is the one that sticks.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    j       = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr_i) + k) % N;
      if (mask_i[j]) begin
        found_o = 1'b1;
        idx_o   = 3'(j);
      end
    end
  end
endmodule

// File: rtl/act_sram_arbiter.sv
// rtl/act_sram_arbiter.sv - round-robin dual-port arbiter for the activation SRAM with read-data return
// Optional ACT_ARB_PERF_EN adds saturating grant/stall counters.
module act_sram_arbiter
  import act_sram_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = act_sram_pkg::ADDR_W,
  parameter int DATA_W  = act_sram_pkg::DATA_W,
  parameter int DEPTH   = act_sram_pkg::DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [4*NUM_REQ-1:0]        req_wea,
  input  logic [ADDR_W*NUM_REQ-1:0]   req_addr,
  input  logic [DATA_W*NUM_REQ-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W*NUM_REQ-1:0]   rsp_rdata,
  output logic [3:0]                  sram_wea0,
  output logic [ADDR_W-1:0]           sram_addr0,
  output logic [DATA_W-1:0]           sram_wdata0,
  input  logic [DATA_W-1:0]           sram_rdata0,
  output logic [3:0]                  sram_wea1,
  output logic [ADDR_W-1:0]           sram_addr1,
  output logic [DATA_W-1:0]           sram_wdata1,
  input  logic [DATA_W-1:0]           sram_rdata1
`ifdef ACT_ARB_PERF_EN
  ,
  output logic [31:0]                 perf_grant_cnt,
  output logic [31:0]                 perf_stall_cnt
`endif
);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [NUM_REQ-1:0]        elig, mask_b;
  logic [2:0]                rr_ptr_q, rr_ptr_d, a_idx, b_idx;
  logic                      a_found, b_found, gnt_a, gnt_b;
  logic [ADDR_W-1:0]         addr_a, addr_b;
  logic [3:0]                wea_a, wea_b;
  logic [DATA_W-1:0]         wdata_a, wdata_b, rd0, rd1;
  logic                      hit0, hit1;
  rsp_tag_t                  tag0_q, tag0_d, tag1_q, tag1_d;
  logic [DATA_W*NUM_REQ-1:0] hold_q;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      elig[i] = req_valid[i] && ({1'b0, req_addr[i*ADDR_W +: ADDR_W]} < DEPTH_L);
  end

  act_rr_picker #(.N(NUM_REQ)) u_pick_a (
    .mask_i(elig), .ptr_i(rr_ptr_q), .idx_o(a_idx), .found_o(a_found)
  );

  assign addr_a  = req_addr[int'(a_idx)*ADDR_W +: ADDR_W];
  assign wea_a   = req_wea[int'(a_idx)*4 +: 4];
  assign wdata_a = req_wdata[int'(a_idx)*DATA_W +: DATA_W];

  // Port 1 may share port 0's address only when both sides are reads.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      mask_b[i] = elig[i] && (3'(i) != a_idx) &&
                  !((req_addr[i*ADDR_W +: ADDR_W] == addr_a) &&
                    ((req_wea[i*4 +: 4] | wea_a) != 4'b0000));
  end

  act_rr_picker #(.N(NUM_REQ)) u_pick_b (
    .mask_i(mask_b), .ptr_i(rr_ptr_q), .idx_o(b_idx), .found_o(b_found)
  );

  assign addr_b  = req_addr[int'(b_idx)*ADDR_W +: ADDR_W];
  assign wea_b   = req_wea[int'(b_idx)*4 +: 4];
  assign wdata_b = req_wdata[int'(b_idx)*DATA_W +: DATA_W];

  assign gnt_a = a_found && !rst;
  assign gnt_b = b_found && !rst;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      req_ready[i] = (gnt_a && (a_idx == 3'(i))) || (gnt_b && (b_idx == 3'(i)));
  end

  // An idle port 1 mirrors port 0's address so the SRAM ignores it.
  assign sram_wea0   = gnt_a ? wea_a   : 4'b0000;
  assign sram_addr0  = gnt_a ? addr_a  : '0;
  assign sram_wdata0 = gnt_a ? wdata_a : '0;
  assign sram_wea1   = gnt_b ? wea_b   : 4'b0000;
  assign sram_addr1  = gnt_b ? addr_b  : sram_addr0;
  assign sram_wdata1 = gnt_b ? wdata_b : '0;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_b)
      rr_ptr_d = (b_idx == 3'(NUM_REQ - 1)) ? 3'd0 : b_idx + 3'd1;
    else if (gnt_a)
      rr_ptr_d = (a_idx == 3'(NUM_REQ - 1)) ? 3'd0 : a_idx + 3'd1;
    tag0_d = '{vld: gnt_a && (wea_a == 4'b0000), port: 1'b0, id: a_idx};
    tag1_d = '{vld: gnt_b && (wea_b == 4'b0000), port: 1'b1, id: b_idx};
  end

  assign rd0 = tag0_q.port ? sram_rdata1 : sram_rdata0;
  assign rd1 = tag1_q.port ? sram_rdata1 : sram_rdata0;

  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    hit0      = 1'b0;
    hit1      = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      hit0 = tag0_q.vld && (tag0_q.id == 3'(i));
      hit1 = tag1_q.vld && (tag1_q.id == 3'(i));
      rsp_valid[i] = !rst && (hit0 || hit1);
      if (rst)
        rsp_rdata[i*DATA_W +: DATA_W] = '0;
      else if (hit0)
        rsp_rdata[i*DATA_W +: DATA_W] = rd0;
      else if (hit1)
        rsp_rdata[i*DATA_W +: DATA_W] = rd1;
      else
        rsp_rdata[i*DATA_W +: DATA_W] = hold_q[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      tag0_q   <= '0;
      tag1_q   <= '0;
      hold_q   <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      tag0_q   <= tag0_d;
      tag1_q   <= tag1_d;
      hold_q   <= rsp_rdata;
    end
  end

`ifdef ACT_ARB_PERF_EN
  logic [31:0] perf_grant_q, perf_grant_d, perf_stall_q, perf_stall_d;
  logic [32:0] grant_sum;

  always_comb begin
    grant_sum    = {1'b0, perf_grant_q} + 33'(gnt_a) + 33'(gnt_b);
    perf_grant_d = grant_sum[32] ? 32'hFFFF_FFFF : grant_sum[31:0];
    perf_stall_d = perf_stall_q;
    if (|(elig & ~req_ready) && (perf_stall_q != 32'hFFFF_FFFF))
      perf_stall_d = perf_stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_grant_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_grant_q <= perf_grant_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_grant_cnt = perf_grant_q;
  assign perf_stall_cnt = perf_stall_q;
`endif
endmodule

// File: tb/tb_act_sram_arbiter.sv
// tb/tb_act_sram_arbiter.sv - directed scoreboard bench for act_sram_arbiter with a dual-port SRAM model
module tb_act_sram_arbiter;
  localparam int NR = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req_valid;
  logic [4*NR-1:0]  req_wea;
  logic [16*NR-1:0] req_addr;
  logic [32*NR-1:0] req_wdata;
  logic [NR-1:0] req_ready, rsp_valid;
  logic [32*NR-1:0] rsp_rdata;
  logic [3:0]    sram_wea0, sram_wea1;
  logic [15:0]   sram_addr0, sram_addr1;
  logic [31:0]   sram_wdata0, sram_wdata1, sram_rdata0, sram_rdata1;
`ifdef ACT_ARB_PERF_EN
  logic [31:0]   perf_grant_cnt, perf_stall_cnt;
`endif

  act_sram_arbiter #(.NUM_REQ(NR)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_wea(req_wea), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .sram_wea0(sram_wea0), .sram_addr0(sram_addr0), .sram_wdata0(sram_wdata0), .sram_rdata0(sram_rdata0),
    .sram_wea1(sram_wea1), .sram_addr1(sram_addr1), .sram_wdata1(sram_wdata1), .sram_rdata1(sram_rdata1)
`ifdef ACT_ARB_PERF_EN
    , .perf_grant_cnt(perf_grant_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // SRAM model: 1-cycle read latency, port 1 write skipped on equal addresses.
  logic [31:0] mem [0:1023];
  initial for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + 32'(i);

  always @(posedge clk) begin
    sram_rdata0 <= mem[sram_addr0[9:0]];
    sram_rdata1 <= mem[sram_addr1[9:0]];
    for (int b = 0; b < 4; b++) begin
      if (sram_wea0[b]) mem[sram_addr0[9:0]][b*8 +: 8] <= sram_wdata0[b*8 +: 8];
      if (sram_wea1[b] && (sram_addr1 != sram_addr0))
        mem[sram_addr1[9:0]][b*8 +: 8] <= sram_wdata1[b*8 +: 8];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q [NR][$];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < NR; i++) begin
      if (rsp_valid[i] === 1'b1) begin
        if (exp_q[i].size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rsp%0d_unexpected: got rsp_valid=1 expected no response", i);
        end else begin
          chk($sformatf("rsp%0d_rdata", i), rsp_rdata[i*32 +: 32], exp_q[i].pop_front());
        end
      end
    end
  end

  task automatic set_req(int i, logic v, logic [3:0] w, logic [15:0] a, logic [31:0] d);
    req_valid[i]         = v;
    req_wea[i*4 +: 4]    = w;
    req_addr[i*16 +: 16] = a;
    req_wdata[i*32 +: 32] = d;
  endtask

  task automatic clear_all();
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, 4'h0, 16'h0, 32'h0);
  endtask

  task automatic check_cycle(string tag, logic [2:0] rdy, logic [3:0] w0, logic [15:0] a0,
                             logic [3:0] w1, logic [15:0] a1, bit rsp_zero);
    @(negedge clk);
    chk({tag, ".ready"}, 32'(req_ready), 32'(rdy));
    chk({tag, ".wea0"},  32'(sram_wea0), 32'(w0));
    chk({tag, ".addr0"}, 32'(sram_addr0), 32'(a0));
    chk({tag, ".wea1"},  32'(sram_wea1), 32'(w1));
    chk({tag, ".addr1"}, 32'(sram_addr1), 32'(a1));
    if (rsp_zero) chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    clear_all();
    set_req(0, 1'b1, 4'h0, 16'h010, 32'h0);
    set_req(1, 1'b1, 4'h0, 16'h020, 32'h0);
    set_req(2, 1'b1, 4'h0, 16'h030, 32'h0);
    repeat (3) check_cycle("reset", 3'b000, 4'h0, 16'h0, 4'h0, 16'h0, 1'b1);
    rst = 1'b0;

    exp_q[0].push_back(32'h1000_0010); exp_q[1].push_back(32'h1000_0020);
    check_cycle("fair1", 3'b011, 4'h0, 16'h010, 4'h0, 16'h020, 1'b0);
    exp_q[2].push_back(32'h1000_0030); exp_q[0].push_back(32'h1000_0010);
    check_cycle("fair2", 3'b101, 4'h0, 16'h030, 4'h0, 16'h010, 1'b0);
    exp_q[1].push_back(32'h1000_0020); exp_q[2].push_back(32'h1000_0030);
    check_cycle("fair3", 3'b110, 4'h0, 16'h020, 4'h0, 16'h030, 1'b0);
    clear_all();

    set_req(0, 1'b1, 4'hF, 16'h0A5, 32'hDEAD_BEEF);
    set_req(1, 1'b1, 4'h0, 16'h0A5, 32'h0);
    check_cycle("coll1", 3'b001, 4'hF, 16'h0A5, 4'h0, 16'h0A5, 1'b0);
    set_req(0, 1'b0, 4'h0, 16'h0, 32'h0);
    exp_q[1].push_back(32'hDEAD_BEEF);
    check_cycle("coll2", 3'b010, 4'h0, 16'h0A5, 4'h0, 16'h0A5, 1'b0);
    clear_all();

    set_req(1, 1'b1, 4'h3, 16'h000, 32'hCAFE_1234);
    check_cycle("swr", 3'b010, 4'h3, 16'h000, 4'h0, 16'h000, 1'b0);
    set_req(1, 1'b1, 4'h0, 16'h000, 32'h0);
    exp_q[1].push_back(32'h1000_1234);
    check_cycle("swr_rd", 3'b010, 4'h0, 16'h000, 4'h0, 16'h000, 1'b0);
    clear_all();

    set_req(0, 1'b1, 4'h0, 16'h3FF, 32'h0);
    set_req(1, 1'b1, 4'h0, 16'h400, 32'h0);
    set_req(2, 1'b1, 4'h0, 16'h3FF, 32'h0);
    exp_q[2].push_back(32'h1000_03FF); exp_q[0].push_back(32'h1000_03FF);
    check_cycle("dual", 3'b101, 4'h0, 16'h3FF, 4'h0, 16'h3FF, 1'b0);
    set_req(0, 1'b0, 4'h0, 16'h0, 32'h0);
    set_req(2, 1'b0, 4'h0, 16'h0, 32'h0);
    repeat (2) check_cycle("oor", 3'b000, 4'h0, 16'h0, 4'h0, 16'h0, 1'b0);
    clear_all();

    set_req(1, 1'b1, 4'h0, 16'h020, 32'h0);
    check_cycle("pre_rst", 3'b010, 4'h0, 16'h020, 4'h0, 16'h020, 1'b0);
    clear_all();
    rst = 1'b1;
    check_cycle("mid_rst", 3'b000, 4'h0, 16'h0, 4'h0, 16'h0, 1'b1);
    rst = 1'b0;
    set_req(0, 1'b1, 4'h0, 16'h010, 32'h0);
    set_req(1, 1'b1, 4'h0, 16'h020, 32'h0);
    set_req(2, 1'b1, 4'h0, 16'h030, 32'h0);
    exp_q[0].push_back(32'h1000_0010); exp_q[1].push_back(32'h1000_0020);
    check_cycle("post_rst", 3'b011, 4'h0, 16'h010, 4'h0, 16'h020, 1'b0);
    clear_all();
    repeat (3) check_cycle("idle", 3'b000, 4'h0, 16'h0, 4'h0, 16'h0, 1'b0);

    for (int i = 0; i < NR; i++)
      chk($sformatf("pending_rsp%0d", i), 32'(exp_q[i].size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
